lfsr_checker: RTL and testbench

//  Receive-side checker for the 128-bit pseudo-random word stream produced by the platform LFSR generator.
//  - Polynomial: x^128+x^29+x^27+x^2+1, Galois form, feedback from bit 127.
//  - Self-synchronises to incoming words, then flywheels its own expected sequence.
//  - Reports lock status, per-word error pulses and saturating word counters to the verification platform.

---
 rtl/lfsr_checker_pkg.sv | 34 +++
 rtl/lfsr_checker_if.sv | 40 ++++
 rtl/lfsr_checker_next.sv | 16 +
 rtl/lfsr_checker.sv | 154 +++++++++++++++
 tb/tb_lfsr_checker.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_checker_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_checker_pkg
// Shared constants and types for the 128-bit LFSR stream checker.
//   LFSR_W        : word width of the pseudo-random stream
//   LFSR_TAP_MASK : Galois feedback mask for x^128+x^29+x^27+x^2+1
//   LFSR_SEED     : generator start value
//   state_t       : checker state (HUNT / LOCKED)
//   popcount128   : bit count helper, only referenced when
//                   LFSR_CHK_BITERR_EN is defined
// ---------------------------------------------------------------------------
package lfsr_checker_pkg;

  localparam int LFSR_W = 128;

  // Bit 0 carries the "+1" term of the polynomial; bits 2, 27 and 29 carry
  // the remaining taps. All four are fed from the bit shifted out of bit 127.
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 128'h2800_0005;
  localparam logic [LFSR_W-1:0] LFSR_SEED     = 128'h5350_4402;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [7:0] popcount128(input logic [LFSR_W-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < LFSR_W; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// ---------------------------------------------------------------------------
// lfsr_checker_if
// Bundle between the stream source / platform and the checker.
//   clr         : synchronous clear of statistics (source -> checker)
//   in_valid    : in_data carries a stream word this cycle
//   in_data     : received 128-bit word
//   locked      : checker is in LOCKED
//   err_pulse   : 1-cycle pulse for a mismatching LOCKED word
//   word_cnt    : words checked while LOCKED (saturating)
//   err_cnt     : mismatching words while LOCKED (saturating)
//   bit_err_cnt : erroneous bits while LOCKED (saturating, 0 unless
//                 LFSR_CHK_BITERR_EN is defined)
// Modports: master = stream source / platform, slave = checker.
// ---------------------------------------------------------------------------
interface lfsr_checker_if
  import lfsr_checker_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic              clr;
  logic              in_valid;
  logic [LFSR_W-1:0] in_data;
  logic              locked;
  logic              err_pulse;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  bit_err_cnt;

  modport master (
    output clr, in_valid, in_data,
    input  locked, err_pulse, word_cnt, err_cnt, bit_err_cnt
  );

  modport slave (
    input  clr, in_valid, in_data,
    output locked, err_pulse, word_cnt, err_cnt, bit_err_cnt
  );

endinterface

// File: rtl/lfsr_checker_next.sv
// ---------------------------------------------------------------------------
// lfsr_checker_next
// Combinational single step of the Galois LFSR.
//   cur : current 128-bit state
//   nxt : state after one generator step
// ---------------------------------------------------------------------------
module lfsr_checker_next
  import lfsr_checker_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = {cur[LFSR_W-2:0], 1'b0} ^ (cur[LFSR_W-1] ? LFSR_TAP_MASK : '0);

endmodule

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the 128-bit LFSR word stream. In HUNT it seeds
// its expectation from every received word until LOCK_CNT consecutive words
// follow the sequence; in LOCKED it flywheels its own sequence, counts
// words/errors and drops back to HUNT after LOSS_THR consecutive misses.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : lfsr_checker_if.slave (clr, in_valid, in_data in; locked,
//         err_pulse, word_cnt, err_cnt, bit_err_cnt out)
// Parameters: LOCK_CNT, LOSS_THR, CNT_W (counter width, saturating)
// Optional feature: define LFSR_CHK_BITERR_EN to accumulate per-bit errors
// in bit_err_cnt; otherwise bit_err_cnt is tied to 0.
// ---------------------------------------------------------------------------
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
)(
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  bus
);

  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(LOSS_THR + 1);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] exp_q;
  logic [LFSR_W-1:0] step_in, step_exp;
  logic              seen_q;
  logic [MR_W-1:0]   match_run_q, match_inc;
  logic [MS_W-1:0]   miss_run_q, miss_inc;
  logic              hunt_match, lock_match, lock_hit, loss_hit;
  logic [CNT_W-1:0]  word_cnt_q, err_cnt_q;
  logic              err_pulse_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  lfsr_checker_next u_step_in  (.cur(bus.in_data), .nxt(step_in));
  lfsr_checker_next u_step_exp (.cur(exp_q),       .nxt(step_exp));

  // The all-zero word is the LFSR lockup state and must never count as a match.
  assign hunt_match = seen_q && (bus.in_data == exp_q) && (bus.in_data != '0);
  assign lock_match = (bus.in_data == exp_q);
  assign match_inc  = match_run_q + 1'b1;
  assign miss_inc   = miss_run_q + 1'b1;
  assign lock_hit   = bus.in_valid && (state_q == HUNT) && hunt_match
                      && (match_inc == MR_W'(LOCK_CNT));
  assign loss_hit   = bus.in_valid && (state_q == LOCKED) && !lock_match
                      && (miss_inc == MS_W'(LOSS_THR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:   if (lock_hit) state_d = LOCKED;
      LOCKED: if (loss_hit) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    bus.locked    = (state_q == LOCKED);
    bus.err_pulse = err_pulse_q;
    bus.word_cnt  = word_cnt_q;
    bus.err_cnt   = err_cnt_q;
  end

  // Tracking and statistics. In LOCKED the expectation is stepped from its
  // own value so corrupted words never reseed it. clr is applied last so it
  // overrides an increment from the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q       <= '0;
      seen_q      <= 1'b0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.in_valid) begin
        if (state_q == HUNT) begin
          exp_q  <= step_in;
          seen_q <= 1'b1;
          if (hunt_match) begin
            match_run_q <= match_inc;
            if (lock_hit) miss_run_q <= '0;
          end else begin
            match_run_q <= '0;
          end
        end else begin
          exp_q      <= step_exp;
          word_cnt_q <= sat_inc(word_cnt_q);
          if (!lock_match) begin
            err_cnt_q   <= sat_inc(err_cnt_q);
            err_pulse_q <= 1'b1;
            miss_run_q  <= miss_inc;
            if (loss_hit) begin
              seen_q      <= 1'b0;
              match_run_q <= '0;
            end
          end else begin
            miss_run_q <= '0;
          end
        end
      end
      if (bus.clr) begin
        word_cnt_q  <= '0;
        err_cnt_q   <= '0;
        err_pulse_q <= 1'b0;
      end
    end
  end

`ifdef LFSR_CHK_BITERR_EN
  localparam int SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;

  logic [CNT_W-1:0] bit_err_cnt_q;
  logic [7:0]       bit_errs;
  logic [SUM_W-1:0] bit_sum;

  assign bit_errs = popcount128(bus.in_data ^ exp_q);
  assign bit_sum  = SUM_W'(bit_err_cnt_q) + SUM_W'(bit_errs);

  // Sum is formed one bit wider than either operand so overflow can be
  // detected and clamped to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_err_cnt_q <= '0;
    end else if (bus.clr) begin
      bit_err_cnt_q <= '0;
    end else if (bus.in_valid && (state_q == LOCKED)) begin
      bit_err_cnt_q <= (bit_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : bit_sum[CNT_W-1:0];
    end
  end

  assign bus.bit_err_cnt = bit_err_cnt_q;
`else
  assign bus.bit_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
// Self-checking bench for lfsr_checker. Two instances share one stimulus
// stream: a 32-bit counter build and a 4-bit counter build (saturation).
// A behavioural model tracks the expected checker outputs.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_THR = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(32)) bus  ();
  lfsr_checker_if #(.CNT_W(4))  bus4 ();

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit           m_locked, m_seen, m_pulse;
  logic [127:0] m_exp;
  int           m_match, m_miss;
  longint       m_wc, m_ec, m_bec;

  logic [127:0] gen_word;

  // Multiply by x modulo x^128+x^29+x^27+x^2+1
  function automatic logic [127:0] poly_step(input logic [127:0] x);
    logic [127:0] r;
    logic [127:0] red;
    red = (128'd1 << 29) | (128'd1 << 27) | (128'd1 << 2) | 128'd1;
    r = x << 1;
    if (x[127]) r = r ^ red;
    return r;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic modelReset();
    m_locked = 0; m_seen = 0; m_pulse = 0; m_exp = '0;
    m_match = 0; m_miss = 0; m_wc = 0; m_ec = 0; m_bec = 0;
  endtask

  task automatic modelStep(input bit v, input logic [127:0] d, input bit c);
    m_pulse = 0;
    if (v) begin
      if (!m_locked) begin
        if (m_seen && d == m_exp && d != '0) begin
          m_match++;
          if (m_match >= LOCK_CNT) begin
            m_locked = 1;
            m_miss = 0;
          end
        end else begin
          m_match = 0;
        end
        m_exp  = poly_step(d);
        m_seen = 1;
      end else begin
        m_wc++;
        if (d != m_exp) begin
          m_ec++;
          m_bec += $countones(d ^ m_exp);
          m_pulse = 1;
          m_miss++;
          if (m_miss >= LOSS_THR) begin
            m_locked = 0;
            m_seen = 0;
            m_match = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_exp = poly_step(m_exp);
      end
    end
    if (c) begin
      m_wc = 0; m_ec = 0; m_bec = 0; m_pulse = 0;
    end
  endtask

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput();
    check("locked",      longint'(bus.locked),    longint'(m_locked));
    check("err_pulse",   longint'(bus.err_pulse), longint'(m_pulse));
    check("word_cnt",    longint'(bus.word_cnt),  sat(m_wc, 32));
    check("err_cnt",     longint'(bus.err_cnt),   sat(m_ec, 32));
    check("locked4",     longint'(bus4.locked),   longint'(m_locked));
    check("word_cnt4",   longint'(bus4.word_cnt), sat(m_wc, 4));
    check("err_cnt4",    longint'(bus4.err_cnt),  sat(m_ec, 4));
`ifdef LFSR_CHK_BITERR_EN
    check("bit_err_cnt",  longint'(bus.bit_err_cnt),  sat(m_bec, 32));
    check("bit_err_cnt4", longint'(bus4.bit_err_cnt), sat(m_bec, 4));
`else
    check("bit_err_cnt",  longint'(bus.bit_err_cnt),  0);
`endif
  endtask

  // Drive one cycle of inputs, let the DUT and model take the edge, compare.
  task automatic applyStimulus(input bit v, input logic [127:0] d, input bit c);
    bus.in_valid  = v; bus.in_data  = d; bus.clr  = c;
    bus4.in_valid = v; bus4.in_data = d; bus4.clr = c;
    @(posedge clk);
    modelStep(v, d, c);
    #1;
    checkOutput();
  endtask

  task automatic feedGen();
    applyStimulus(1'b1, gen_word, 1'b0);
    gen_word = poly_step(gen_word);
  endtask

  task automatic feedIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, rand_word(), 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.clr = 0;
    bus4.in_valid = 0; bus4.in_data = '0; bus4.clr = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
  endtask

  typedef struct {
    logic         valid;
    logic [127:0] data;
    bit           exp_locked;
    int           exp_wc;
  } vec_t;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t         tbl[10];
    logic [127:0] w;
    int           k;

    // ---- Reset state ----
    doReset();

    // ---- 1: clean generator stream, table driven ----
    gen_word = 128'h5350_4402;
    w = gen_word;
    for (int i = 0; i < 10; i++) begin
      tbl[i].valid      = 1'b1;
      tbl[i].data       = w;
      tbl[i].exp_locked = (i >= 4);
      tbl[i].exp_wc     = (i >= 4) ? i - 4 : 0;
      w = poly_step(w);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].valid, tbl[i].data, 1'b0);
      check("tbl_locked",  longint'(bus.locked),   longint'(tbl[i].exp_locked));
      check("tbl_wordcnt", longint'(bus.word_cnt), longint'(tbl[i].exp_wc));
      check("tbl_errcnt",  longint'(bus.err_cnt),  0);
    end
    gen_word = w;

    // ---- 2: single bit flip ----
    applyStimulus(1'b1, gen_word ^ (128'd1 << 5), 1'b0);
    gen_word = poly_step(gen_word);
    check("flip_pulse",  longint'(bus.err_pulse), 1);
    check("flip_errcnt", longint'(bus.err_cnt),   1);
    check("flip_locked", longint'(bus.locked),    1);
`ifdef LFSR_CHK_BITERR_EN
    check("flip_biterr", longint'(bus.bit_err_cnt), 1);
`else
    check("flip_biterr", longint'(bus.bit_err_cnt), 0);
`endif
    feedGen();
    check("flip_next_pulse", longint'(bus.err_pulse), 0);
    check("flip_next_errcnt", longint'(bus.err_cnt), 1);

    // ---- 3: loss of lock after LOSS_THR bad words, then re-lock ----
    for (int i = 0; i < LOSS_THR; i++) begin
      applyStimulus(1'b1, rand_word(), 1'b0);
      gen_word = poly_step(gen_word);
      check("loss_locked", longint'(bus.locked), (i < LOSS_THR - 1) ? 1 : 0);
    end
    check("loss_errcnt", longint'(bus.err_cnt), 9);
    for (int i = 0; i < LOCK_CNT + 1; i++) begin
      feedGen();
      check("relock_locked", longint'(bus.locked), (i == LOCK_CNT) ? 1 : 0);
    end

    // ---- 4: all-zero words never lock; gapped stream still locks ----
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, '0, 1'b0);
      check("zero_locked", longint'(bus.locked), 0);
    end
    for (int i = 0; i < 10; i++) begin
      feedGen();
      feedIdle(2);
    end
    check("gap_locked",  longint'(bus.locked),   1);
    check("gap_errcnt",  longint'(bus.err_cnt),  0);
    check("gap_wordcnt", longint'(bus.word_cnt), 5);

    // ---- 5: saturation on the 4-bit build, then clr ----
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, gen_word ^ (128'd1 << (i * 6)), 1'b0);
      gen_word = poly_step(gen_word);
      feedGen();
    end
    check("sat_errcnt4",  longint'(bus4.err_cnt),  15);
    check("sat_wordcnt4", longint'(bus4.word_cnt), 15);
    check("sat_errcnt",   longint'(bus.err_cnt),   20);
    applyStimulus(1'b1, gen_word, 1'b1);
    gen_word = poly_step(gen_word);
    check("clr_errcnt4",  longint'(bus4.err_cnt),  0);
    check("clr_wordcnt",  longint'(bus.word_cnt),  0);
    check("clr_locked",   longint'(bus.locked),    1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      if (k < 25) begin
        applyStimulus(1'b0, rand_word(), ($urandom_range(0, 49) == 0));
      end else begin
        if ($urandom_range(0, 9) < 8) begin
          applyStimulus(1'b1, gen_word, ($urandom_range(0, 49) == 0));
        end else if ($urandom_range(0, 1) == 0) begin
          applyStimulus(1'b1, gen_word ^ (128'd1 << $urandom_range(0, 127)), 1'b0);
        end else begin
          applyStimulus(1'b1, rand_word(), 1'b0);
        end
        gen_word = poly_step(gen_word);
      end
    end

    // ---- 6: asynchronous reset mid-stream while locked ----
    for (int i = 0; i < LOCK_CNT + 3; i++) feedGen();
    check("pre_rst_locked", longint'(bus.locked), 1);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    check("rst_locked",  longint'(bus.locked),   0);
    check("rst_wordcnt", longint'(bus.word_cnt), 0);
    check("rst_errcnt",  longint'(bus.err_cnt),  0);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < LOCK_CNT + 1; i++) begin
      feedGen();
      check("rst_relock", longint'(bus.locked), (i == LOCK_CNT) ? 1 : 0);
    end
    feedGen();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
